// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - shared funct3 codes, state enum and decode helpers for ex_muldiv
package muldiv_pkg;

  localparam logic [2:0] MD_MUL    = 3'b000;
  localparam logic [2:0] MD_MULH   = 3'b001;
  localparam logic [2:0] MD_MULHSU = 3'b010;
  localparam logic [2:0] MD_MULHU  = 3'b011;
  localparam logic [2:0] MD_DIV    = 3'b100;
  localparam logic [2:0] MD_DIVU   = 3'b101;
  localparam logic [2:0] MD_REM    = 3'b110;
  localparam logic [2:0] MD_REMU   = 3'b111;

  // State names carry ST_ so they do not collide with the funct3 codes above.
  typedef enum logic [1:0] {
    MD_ST_IDLE = 2'd0,
    MD_ST_MUL  = 2'd1,
    MD_ST_DIV  = 2'd2,
    MD_ST_DONE = 2'd3
  } md_state_t;

  function automatic logic is_div(input logic [2:0] funct3);
    return funct3[2];
  endfunction

  function automatic logic is_signed_a(input logic [2:0] funct3);
    return (funct3 == MD_MULH) || (funct3 == MD_MULHSU) ||
           (funct3 == MD_DIV)  || (funct3 == MD_REM);
  endfunction

  function automatic logic is_signed_b(input logic [2:0] funct3);
    return (funct3 == MD_MULH) || (funct3 == MD_DIV) || (funct3 == MD_REM);
  endfunction

endpackage

// File: rtl/ex_div_step.sv
// rtl/ex_div_step.sv - combinational UNROLL-bit restoring divide step
module ex_div_step #(
  parameter int XLEN   = 32,
  parameter int UNROLL = 1
) (
  input  logic [XLEN-1:0] rem_in,
  input  logic [XLEN-1:0] quot_in,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] rem_out,
  output logic [XLEN-1:0] quot_out
);

  logic [XLEN-1:0] r;
  logic [XLEN-1:0] q;
  logic [XLEN:0]   sh;

  // Shift the next dividend bit into the partial remainder, subtract when it fits.
  // The shifted remainder needs one extra bit since it can reach twice the divisor.
  always_comb begin
    r  = rem_in;
    q  = quot_in;
    sh = '0;
    for (int i = 0; i < UNROLL; i++) begin
      sh = {r, q[XLEN-1]};
      q  = {q[XLEN-2:0], 1'b0};
      if (sh >= {1'b0, divisor}) begin
        sh   = sh - {1'b0, divisor};
        q[0] = 1'b1;
      end
      r = sh[XLEN-1:0];
    end
    rem_out  = r;
    quot_out = q;
  end

endmodule

// File: rtl/ex_muldiv.sv
// rtl/ex_muldiv.sv - iterative RV32M multiply/divide unit for the EX stage
module ex_muldiv
  import muldiv_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int UNROLL = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            MDStartE,
  input  logic [2:0]      MDFunct3E,
  input  logic [XLEN-1:0] SrcAE,
  input  logic [XLEN-1:0] SrcBE,
  input  logic            FlushE,
  output logic            MDBusyE,
  output logic            MDValidE,
  output logic [XLEN-1:0] MDResultE
);

  localparam int N  = XLEN / UNROLL;
  localparam int CW = $clog2(N) + 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  md_state_t       state;
  logic [2:0]      f3_q;
  logic [XLEN-1:0] a_q, b_q;
  logic            sign_a_q, sign_b_q;
  logic [CW-1:0]   cnt;
  logic [XLEN-1:0] rem_q, quot_q;

  logic            accept, in_div, div_zero, div_ovf;
  logic [XLEN-1:0] a_mag_in, special_res;
  logic [XLEN-1:0] b_mag, rem_nx, quot_nx, q_res, r_res, div_res, mul_res;
  logic [2*XLEN-1:0] ext_a, ext_b, prod;

  // Start decode and special-case detection on the incoming operands.
  always_comb begin
    accept   = MDStartE && !FlushE && (state == MD_ST_IDLE || state == MD_ST_DONE);
    in_div   = is_div(MDFunct3E);
    div_zero = (SrcBE == '0);
    div_ovf  = is_signed_a(MDFunct3E) && (SrcAE == {1'b1, {(XLEN-1){1'b0}}}) && (SrcBE == '1);
    a_mag_in = (is_signed_a(MDFunct3E) && SrcAE[XLEN-1]) ? -SrcAE : SrcAE;
    if (div_zero) special_res = MDFunct3E[1] ? SrcAE : '1;
    else          special_res = MDFunct3E[1] ? '0 : SrcAE;
  end

  ex_div_step #(.XLEN(XLEN), .UNROLL(UNROLL)) u_step (
    .rem_in  (rem_q),
    .quot_in (quot_q),
    .divisor (b_mag),
    .rem_out (rem_nx),
    .quot_out(quot_nx)
  );

  // Result formation from latched operands: product halves and sign-fixed divide outputs.
  always_comb begin
    b_mag   = sign_b_q ? -b_q : b_q;
    q_res   = (sign_a_q ^ sign_b_q) ? -quot_nx : quot_nx;
    r_res   = sign_a_q ? -rem_nx : rem_nx;
    div_res = f3_q[1] ? r_res : q_res;
    ext_a   = {{XLEN{sign_a_q}}, a_q};
    ext_b   = {{XLEN{sign_b_q}}, b_q};
    prod    = ext_a * ext_b;
    mul_res = (f3_q == MD_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
  end

  // Control FSM with registered busy/valid/result outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= MD_ST_IDLE;
      MDBusyE   <= 1'b0;
      MDValidE  <= 1'b0;
      MDResultE <= '0;
      f3_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      sign_a_q  <= 1'b0;
      sign_b_q  <= 1'b0;
      cnt       <= '0;
      rem_q     <= '0;
      quot_q    <= '0;
    end else begin
      MDValidE <= 1'b0;
      if (FlushE) begin
        state   <= MD_ST_IDLE;
        MDBusyE <= 1'b0;
      end else begin
        case (state)
          MD_ST_IDLE, MD_ST_DONE: begin
            if (accept) begin
              f3_q     <= MDFunct3E;
              a_q      <= SrcAE;
              b_q      <= SrcBE;
              sign_a_q <= is_signed_a(MDFunct3E) & SrcAE[XLEN-1];
              sign_b_q <= is_signed_b(MDFunct3E) & SrcBE[XLEN-1];
              if (!in_div) begin
                state   <= MD_ST_MUL;
                MDBusyE <= 1'b1;
              end else if (div_zero || div_ovf) begin
                state     <= MD_ST_DONE;
                MDBusyE   <= 1'b0;
                MDValidE  <= 1'b1;
                MDResultE <= special_res;
              end else begin
                state   <= MD_ST_DIV;
                MDBusyE <= 1'b1;
                cnt     <= '0;
                rem_q   <= '0;
                quot_q  <= a_mag_in;
              end
            end else begin
              state   <= MD_ST_IDLE;
              MDBusyE <= 1'b0;
            end
          end
          MD_ST_MUL: begin
            state     <= MD_ST_DONE;
            MDBusyE   <= 1'b0;
            MDValidE  <= 1'b1;
            MDResultE <= mul_res;
          end
          MD_ST_DIV: begin
            rem_q  <= rem_nx;
            quot_q <= quot_nx;
            cnt    <= cnt + 1'b1;
            if (cnt == LAST) begin
              state     <= MD_ST_DONE;
              MDBusyE   <= 1'b0;
              MDValidE  <= 1'b1;
              MDResultE <= div_res;
            end
          end
          default: begin
            state   <= MD_ST_IDLE;
            MDBusyE <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ex_muldiv.sv
// tb/tb_ex_muldiv.sv - self-checking bench for ex_muldiv at UNROLL 1 and 4
module tb_ex_muldiv;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        MDStartE = 1'b0;
  logic [2:0]  MDFunct3E = 3'd0;
  logic [31:0] SrcAE = 32'd0;
  logic [31:0] SrcBE = 32'd0;
  logic        FlushE = 1'b0;

  logic        busy1, valid1, busy4, valid4;
  logic [31:0] res1, res4;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  ex_muldiv #(.XLEN(32), .UNROLL(1)) dut (
    .clk(clk), .reset(reset), .MDStartE(MDStartE), .MDFunct3E(MDFunct3E),
    .SrcAE(SrcAE), .SrcBE(SrcBE), .FlushE(FlushE),
    .MDBusyE(busy1), .MDValidE(valid1), .MDResultE(res1)
  );

  ex_muldiv #(.XLEN(32), .UNROLL(4)) dut4 (
    .clk(clk), .reset(reset), .MDStartE(MDStartE), .MDFunct3E(MDFunct3E),
    .SrcAE(SrcAE), .SrcBE(SrcBE), .FlushE(FlushE),
    .MDBusyE(busy4), .MDValidE(valid4), .MDResultE(res4)
  );

  // Reference results from RV32M arithmetic rules.
  function automatic logic [31:0] ref_md(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    int sa, sb;
    sa = a;
    sb = b;
    case (f3)
      3'd0: begin p = {32'd0, a} * {32'd0, b}; return p[31:0]; end
      3'd1: begin p = 64'(longint'(sa) * longint'(sb)); return p[63:32]; end
      3'd2: begin p = 64'(longint'(sa) * longint'({32'd0, b})); return p[63:32]; end
      3'd3: begin p = {32'd0, a} * {32'd0, b}; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
        return 32'(sa / sb);
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        return 32'(sa % sb);
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int ref_lat(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b, input int n);
    if (!f3[2]) return 2;
    if (b == 0) return 1;
    if (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return n + 1;
  endfunction

  // Issue one op at a negedge and observe both DUTs for 60 cycles.
  task automatic do_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                       output int lat1, output int lat4, output logic [31:0] r1, output logic [31:0] r4,
                       output int bz1, output int bz4, output int p1, output int p4);
    lat1 = -1; lat4 = -1; r1 = 'x; r4 = 'x; bz1 = 0; bz4 = 0; p1 = 0; p4 = 0;
    MDFunct3E = f3; SrcAE = a; SrcBE = b; MDStartE = 1'b1;
    @(posedge clk);
    #1 MDStartE = 1'b0;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      if (busy1) bz1++;
      if (busy4) bz4++;
      if (valid1) begin p1++; if (lat1 < 0) begin lat1 = k; r1 = res1; end end
      if (valid4) begin p4++; if (lat4 < 0) begin lat4 = k; r4 = res4; end end
    end
  endtask

  task automatic drain(input int cycles);
    MDStartE = 1'b0;
    FlushE = 1'b0;
    repeat (cycles) @(negedge clk);
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    total++; if ({busy1, valid1, res1} !== 34'd0) $display("FAIL reset_dut1 got busy=%b valid=%b res=%h want 0 0 0", busy1, valid1, res1); else passed++;
    total++; if ({busy4, valid4, res4} !== 34'd0) $display("FAIL reset_dut4 got busy=%b valid=%b res=%h want 0 0 0", busy4, valid4, res4); else passed++;
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic run_checked(input string name, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    int l1, l4, b1, b4, p1, p4;
    logic [31:0] r1, r4, exp;
    int el1, el4;
    exp = ref_md(f3, a, b);
    el1 = ref_lat(f3, a, b, 32);
    el4 = ref_lat(f3, a, b, 8);
    do_op(f3, a, b, l1, l4, r1, r4, b1, b4, p1, p4);
    total++; if (r1 !== exp || r4 !== exp) $display("FAIL %s_result f3=%0d a=%h b=%h got %h/%h want %h", name, f3, a, b, r1, r4, exp); else passed++;
    total++; if (l1 != el1 || l4 != el4) $display("FAIL %s_latency f3=%0d got %0d/%0d want %0d/%0d", name, f3, l1, l4, el1, el4); else passed++;
    total++; if (b1 != el1 - 1 || b4 != el4 - 1) $display("FAIL %s_busy f3=%0d got %0d/%0d want %0d/%0d", name, f3, b1, b4, el1 - 1, el4 - 1); else passed++;
    total++; if (p1 != 1 || p4 != 1) $display("FAIL %s_pulses got %0d/%0d want 1", name, p1, p4); else passed++;
  endtask

  task automatic test_mul;
    logic [31:0] a, b;
    run_checked("mul_fixed", 3'd0, 32'd7, 32'hFFFF_FFFD);
    total++; if (ref_md(3'd0, 32'd7, 32'hFFFF_FFFD) !== 32'hFFFF_FFEB) $display("FAIL mul_model got %h want ffffffeb", ref_md(3'd0, 32'd7, 32'hFFFF_FFFD)); else passed++;
    for (int i = 0; i < 8; i++) begin
      a = $urandom; b = $urandom;
      run_checked("mul_rand", 3'(i % 4), a, b);
    end
  endtask

  task automatic test_high;
    logic [31:0] want [3];
    int l1, l4, b1, b4, p1, p4;
    logic [31:0] r1, r4;
    want[0] = 32'h0000_0000; want[1] = 32'hFFFF_FFFF; want[2] = 32'hFFFF_FFFE;
    for (int i = 1; i <= 3; i++) begin
      do_op(3'(i), 32'hFFFF_FFFF, 32'hFFFF_FFFF, l1, l4, r1, r4, b1, b4, p1, p4);
      total++; if (r1 !== want[i-1] || r4 !== want[i-1] || l1 != 2) $display("FAIL high_half f3=%0d got %h/%h lat %0d want %h lat 2", i, r1, r4, l1, want[i-1]); else passed++;
    end
  endtask

  task automatic test_div;
    logic [31:0] a, b;
    run_checked("div_neg7", 3'd4, 32'hFFFF_FFF9, 32'd2);
    run_checked("rem_neg7", 3'd6, 32'hFFFF_FFF9, 32'd2);
    for (int i = 0; i < 12; i++) begin
      a = $urandom;
      b = $urandom >> $urandom_range(0, 31);
      if (b == 0) b = 32'd3;
      run_checked("div_rand", 3'(4 + (i % 4)), a, b);
    end
  endtask

  task automatic test_special;
    run_checked("divu_zero", 3'd5, 32'd5, 32'd0);
    run_checked("remu_zero", 3'd7, 32'd5, 32'd0);
    run_checked("div_ovf",   3'd4, 32'h8000_0000, 32'hFFFF_FFFF);
    run_checked("rem_ovf",   3'd6, 32'h8000_0000, 32'hFFFF_FFFF);
    run_checked("div_zero_s", 3'd4, 32'hFFFF_FFF0, 32'd0);
  endtask

  task automatic test_flush;
    int l1, l4, b1, b4, p1, p4, stray;
    logic [31:0] r1, r4, a, b;
    do_op(3'd0, 32'd3, 32'd5, l1, l4, r1, r4, b1, b4, p1, p4);
    total++; if (r1 !== 32'd15) $display("FAIL flush_setup got %h want 0000000f", r1); else passed++;
    MDFunct3E = 3'd5; SrcAE = 32'd1000; SrcBE = 32'd7; MDStartE = 1'b1;
    @(posedge clk);
    #1 MDStartE = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (k == 10) FlushE = 1'b1;
    end
    @(posedge clk);
    #1 FlushE = 1'b0;
    @(negedge clk);
    total++; if (busy1 !== 1'b0 || valid1 !== 1'b0 || res1 !== 32'd15) $display("FAIL flush_idle got busy=%b valid=%b res=%h want 0 0 0000000f", busy1, valid1, res1); else passed++;
    a = $urandom; b = $urandom_range(1, 1000);
    do_op(3'd4, a, b, l1, l4, r1, r4, b1, b4, p1, p4);
    total++; if (r1 !== ref_md(3'd4, a, b) || l1 != 33 || p1 != 1) $display("FAIL flush_restart got %h lat %0d pulses %0d want %h lat 33 pulses 1", r1, l1, p1, ref_md(3'd4, a, b)); else passed++;
    // start held during busy: only the first op may complete on dut1
    MDFunct3E = 3'd5; SrcAE = 32'd100; SrcBE = 32'd9; MDStartE = 1'b1;
    @(posedge clk);
    #1 MDFunct3E = 3'd0; SrcAE = 32'd2; SrcBE = 32'd2;
    l1 = -1; stray = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (k == 32) MDStartE = 1'b0;
      if (valid1) begin if (l1 < 0) begin l1 = k; r1 = res1; end else stray++; end
    end
    total++; if (l1 != 33 || r1 !== 32'd11 || stray != 0) $display("FAIL held_start got lat %0d res %h extra %0d want lat 33 res 0000000b extra 0", l1, r1, stray); else passed++;
    drain(40);
  endtask

  task automatic test_back_to_back;
    logic [31:0] a, b, ed, em;
    int v_first, v_second, v_gap, bsy_gap;
    a = $urandom; b = $urandom_range(1, 50000);
    ed = ref_md(3'd7, a, b);
    em = ref_md(3'd1, 32'hFFFF_0003, 32'd123);
    v_first = 0; v_second = 0; v_gap = 1; bsy_gap = 0;
    MDFunct3E = 3'd7; SrcAE = a; SrcBE = b; MDStartE = 1'b1;
    @(posedge clk);
    #1 MDStartE = 1'b0;
    for (int k = 1; k <= 37; k++) begin
      @(negedge clk);
      if (k == 33) begin
        v_first = (valid1 === 1'b1 && res1 === ed) ? 1 : 0;
        MDFunct3E = 3'd1; SrcAE = 32'hFFFF_0003; SrcBE = 32'd123; MDStartE = 1'b1;
      end
      if (k == 34) begin
        v_gap = valid1; bsy_gap = busy1;
        MDStartE = 1'b0;
      end
      if (k == 35) v_second = (valid1 === 1'b1 && res1 === em) ? 1 : 0;
    end
    total++; if (v_first != 1) $display("FAIL b2b_first got valid=%b res=%h want 1 %h", valid1, res1, ed); else passed++;
    total++; if (v_gap != 0 || bsy_gap != 1) $display("FAIL b2b_gap got valid=%0d busy=%0d want 0 1", v_gap, bsy_gap); else passed++;
    total++; if (v_second != 1) $display("FAIL b2b_second got flag %0d res=%h want 1 %h", v_second, res1, em); else passed++;
    drain(40);
  endtask

  task automatic test_reset_mid;
    int stray;
    MDFunct3E = 3'd4; SrcAE = 32'd12345; SrcBE = 32'd7; MDStartE = 1'b1;
    @(posedge clk);
    #1 MDStartE = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      if (k == 5) reset = 1'b1;
    end
    @(negedge clk);
    total++; if ({busy1, valid1, res1, busy4, valid4, res4} !== 68'd0) $display("FAIL reset_mid got busy=%b/%b valid=%b/%b res=%h/%h want all 0", busy1, busy4, valid1, valid4, res1, res4); else passed++;
    reset = 1'b0;
    stray = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (valid1 || valid4 || busy1 || busy4) stray++;
    end
    total++; if (stray != 0) $display("FAIL reset_discard got %0d active cycles want 0", stray); else passed++;
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_mul();
    test_high();
    test_div();
    test_special();
    test_flush();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
